// File: rtl/dcache_miss_ctrl_if.sv
// Pipeline/memory-side bundle for the data-cache miss controller.
// The pipeline/AXI side is the master; the miss controller is the slave.
interface dcache_miss_ctrl_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
);
    logic                  i_mem_access;
    logic                  i_dcache_hit;
    logic                  i_dcache_dirty;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [ADDR_WIDTH-1:0] i_addr_wb;
    logic                  i_axi_wr_done;
    logic                  i_axi_rd_done;
    logic                  o_stall;
    logic                  o_axi_wr_req;
    logic                  o_axi_rd_req;
    logic [ADDR_WIDTH-1:0] o_axi_addr;
    logic                  o_block_we;
    logic [CNT_WIDTH-1:0]  o_miss_cnt;
    logic [CNT_WIDTH-1:0]  o_wb_cnt;

    modport master (
        output i_mem_access, i_dcache_hit, i_dcache_dirty, i_addr, i_addr_wb,
               i_axi_wr_done, i_axi_rd_done,
        input  o_stall, o_axi_wr_req, o_axi_rd_req, o_axi_addr, o_block_we,
               o_miss_cnt, o_wb_cnt
    );

    modport slave (
        input  i_mem_access, i_dcache_hit, i_dcache_dirty, i_addr, i_addr_wb,
               i_axi_wr_done, i_axi_rd_done,
        output o_stall, o_axi_wr_req, o_axi_rd_req, o_axi_addr, o_block_we,
               o_miss_cnt, o_wb_cnt
    );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller: optional dirty writeback, line refill, one-cycle block write.
// Define DCACHE_PERF_CNT_EN to build the saturating miss/writeback counters; otherwise they read 0.
module dcache_miss_ctrl #(
    parameter int ADDR_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic            i_clk,
    input  logic            i_arst_n,
    dcache_miss_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        ALLOCATE  = 2'd3
    } state_e;

    // Refill always fetches a whole 64-byte line.
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(6'h3f);

    state_e state_q, state_d;
    logic   miss;

    assign miss = bus.i_mem_access & ~bus.i_dcache_hit;

    // NOTE: every output and next-state gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_d          = state_q;
        bus.o_stall      = 1'b0;
        bus.o_axi_wr_req = 1'b0;
        bus.o_axi_rd_req = 1'b0;
        bus.o_axi_addr   = '0;
        bus.o_block_we   = 1'b0;
        case (state_q)
            IDLE: begin
                // Stall combinationally so the missing access never leaves the memory stage.
                bus.o_stall = miss;
                if (miss) begin
                    state_d = bus.i_dcache_dirty ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                bus.o_stall      = 1'b1;
                bus.o_axi_wr_req = 1'b1;
                bus.o_axi_addr   = bus.i_addr_wb;
                if (bus.i_axi_wr_done) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                bus.o_stall      = 1'b1;
                bus.o_axi_rd_req = 1'b1;
                bus.o_axi_addr   = bus.i_addr & LINE_MASK;
                if (bus.i_axi_rd_done) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                bus.o_stall    = 1'b1;
                bus.o_block_we = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic                 miss_taken;
    logic                 wb_taken;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
    logic [CNT_WIDTH-1:0] wb_cnt_q, wb_cnt_d;

    always_comb begin
        miss_taken = (state_q == IDLE) && miss;
        wb_taken   = miss_taken && bus.i_dcache_dirty;
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        // Counters stick at all ones rather than wrapping.
        if (miss_taken && !(&miss_cnt_q)) begin
            miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
        end
        if (wb_taken && !(&wb_cnt_q)) begin
            wb_cnt_d = wb_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    assign bus.o_miss_cnt = miss_cnt_q;
    assign bus.o_wb_cnt   = wb_cnt_q;
`else
    assign bus.o_miss_cnt = '0;
    assign bus.o_wb_cnt   = '0;
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Bench for dcache_miss_ctrl: directed miss scenarios, async reset, then random traffic
// against a phase-queue reference model. Honours DCACHE_PERF_CNT_EN for counter expectations.
module tb_dcache_miss_ctrl;

    localparam int AW = 64;
    localparam int CW = 2;

    logic clk;
    logic rst_n;

    dcache_miss_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    dcache_miss_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .i_clk   (clk),
        .i_arst_n(rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: each miss becomes a list of pending bus phases.
    typedef enum {PH_WR, PH_RD, PH_WE} phase_e;
    phase_e ph_q[$];
    int     ph_age;
    int     n_miss, n_wb;

    int vectors, miscompares;
    int stall_seen, we_seen, wr_seen, rd_seen;
    logic [63:0] wr_addr_seen, rd_addr_seen;

    function automatic logic [63:0] exp_cnt(input int n);
`ifdef DCACHE_PERF_CNT_EN
        int mx;
        mx = (1 << CW) - 1;
        return (n > mx) ? 64'(mx) : 64'(n);
`else
        return 64'(0) & 64'(n);
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic acc, input logic hit, input logic dirty,
                         input logic [63:0] addr, input logic [63:0] addr_wb,
                         input logic wr_done, input logic rd_done);
        logic        miss, busy, e_wr, e_rd, e_we;
        logic [63:0] e_addr;
        @(negedge clk);
        bus.i_mem_access   = acc;
        bus.i_dcache_hit   = hit;
        bus.i_dcache_dirty = dirty;
        bus.i_addr         = addr;
        bus.i_addr_wb      = addr_wb;
        bus.i_axi_wr_done  = wr_done;
        bus.i_axi_rd_done  = rd_done;
        #1;
        miss   = acc & ~hit;
        busy   = ph_q.size() != 0;
        e_wr   = busy && ph_q[0] == PH_WR;
        e_rd   = busy && ph_q[0] == PH_RD;
        e_we   = busy && ph_q[0] == PH_WE;
        e_addr = e_wr ? addr_wb : (e_rd ? {addr[63:6], 6'b0} : 64'h0);
        check("stall",    64'(bus.o_stall), 64'(busy | miss));
        check("wr_req",   64'(bus.o_axi_wr_req), 64'(e_wr));
        check("rd_req",   64'(bus.o_axi_rd_req), 64'(e_rd));
        check("req_excl", 64'(bus.o_axi_wr_req & bus.o_axi_rd_req), 64'h0);
        check("axi_addr", bus.o_axi_addr, e_addr);
        check("block_we", 64'(bus.o_block_we), 64'(e_we));
        check("miss_cnt", 64'(bus.o_miss_cnt), exp_cnt(n_miss));
        check("wb_cnt",   64'(bus.o_wb_cnt), exp_cnt(n_wb));
        if (bus.o_stall)      stall_seen++;
        if (bus.o_block_we)   we_seen++;
        if (bus.o_axi_wr_req) begin wr_seen++; wr_addr_seen = bus.o_axi_addr; end
        if (bus.o_axi_rd_req) begin rd_seen++; rd_addr_seen = bus.o_axi_addr; end
        @(posedge clk);
        if (busy) begin
            if ((ph_q[0] == PH_WE) || (ph_q[0] == PH_WR && wr_done) ||
                (ph_q[0] == PH_RD && rd_done)) begin
                void'(ph_q.pop_front());
                ph_age = 0;
            end else begin
                ph_age++;
            end
        end else if (miss) begin
            n_miss++;
            if (dirty) begin
                n_wb++;
                ph_q.push_back(PH_WR);
            end
            ph_q.push_back(PH_RD);
            ph_q.push_back(PH_WE);
            ph_age = 0;
        end
    endtask

    // One full miss; done pulses land on the wr_lat-th / rd_lat-th cycle of their phase.
    task automatic run_miss(input logic [63:0] addr, input logic dirty, input logic [63:0] addr_wb,
                            input int wr_lat, input int rd_lat, input logic spurious_rd);
        logic wr, rd;
        stall_seen = 0; we_seen = 0; wr_seen = 0; rd_seen = 0;
        wr_addr_seen = '0; rd_addr_seen = '0;
        cycle(1'b1, 1'b0, dirty, addr, addr_wb, 1'b0, 1'b0);
        for (int i = 0; i < 64 && ph_q.size() != 0; i++) begin
            wr = (ph_q[0] == PH_WR) && (ph_age == wr_lat - 1);
            rd = ((ph_q[0] == PH_RD) && (ph_age == rd_lat - 1)) ||
                 (spurious_rd && ph_q[0] == PH_WR && ph_age == 0);
            // Hit/dirty are scrambled while busy; the controller must ignore them.
            cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, addr_wb, wr, rd);
        end
        cycle(1'b1, 1'b1, 1'b0, addr, addr_wb, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input logic miss_in);
        @(negedge clk);
        bus.i_mem_access  = miss_in;
        bus.i_dcache_hit  = 1'b0;
        bus.i_axi_wr_done = 1'b0;
        bus.i_axi_rd_done = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        ph_q.delete();
        ph_age = 0; n_miss = 0; n_wb = 0;
        check("rst_wr_req",   64'(bus.o_axi_wr_req), 64'h0);
        check("rst_rd_req",   64'(bus.o_axi_rd_req), 64'h0);
        check("rst_block_we", 64'(bus.o_block_we), 64'h0);
        check("rst_addr",     bus.o_axi_addr, 64'h0);
        check("rst_stall",    64'(bus.o_stall), 64'(miss_in));
        check("rst_miss_cnt", 64'(bus.o_miss_cnt), 64'h0);
        check("rst_wb_cnt",   64'(bus.o_wb_cnt), 64'h0);
        @(posedge clk);
        #1;
        check("rst_hold_stall", 64'(bus.o_stall), 64'(miss_in));
        check("rst_hold_rd",    64'(bus.o_axi_rd_req), 64'h0);
        @(negedge clk);
        bus.i_mem_access = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        ph_age = 0; n_miss = 0; n_wb = 0;
        rst_n              = 1'b0;
        bus.i_mem_access   = 1'b0;
        bus.i_dcache_hit   = 1'b0;
        bus.i_dcache_dirty = 1'b0;
        bus.i_addr         = '0;
        bus.i_addr_wb      = '0;
        bus.i_axi_wr_done  = 1'b0;
        bus.i_axi_rd_done  = 1'b0;
        #1;
        check("init_stall",  64'(bus.o_stall), 64'h0);
        check("init_rd_req", 64'(bus.o_axi_rd_req), 64'h0);
        do_reset(1'b1);

        // Hits and non-accesses never stall or request.
        cycle(1'b1, 1'b1, 1'b1, 64'h1048, 64'h2000, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 64'h1048, 64'h2000, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 64'h3000, 64'h2000, 1'b0, 1'b1);
        check("hit_miss_cnt", 64'(bus.o_miss_cnt), exp_cnt(0));

        // Clean miss, read completes on the fifth refill cycle.
        run_miss(64'h1048, 1'b0, 64'h2000, 1, 5, 1'b0);
        check("clean_stall_cycles", 64'(stall_seen), 64'd7);
        check("clean_rd_addr",      rd_addr_seen, 64'h1040);
        check("clean_we_pulses",    64'(we_seen), 64'd1);
        check("clean_miss_cnt",     64'(bus.o_miss_cnt), exp_cnt(1));

        // Fastest clean miss.
        run_miss(64'h5a7f, 1'b0, 64'h0, 1, 1, 1'b0);
        check("clean_min_latency", 64'(stall_seen), 64'd3);

        // Dirty miss with a stray read-done during writeback.
        do_reset(1'b0);
        run_miss(64'h30c5, 1'b1, 64'h2000, 3, 1, 1'b1);
        check("dirty_stall_cycles", 64'(stall_seen), 64'd6);
        check("dirty_wr_cycles",    64'(wr_seen), 64'd3);
        check("dirty_wr_addr",      wr_addr_seen, 64'h2000);
        check("dirty_rd_addr",      rd_addr_seen, 64'h30c0);
        check("dirty_miss_cnt",     64'(bus.o_miss_cnt), exp_cnt(1));
        check("dirty_wb_cnt",       64'(bus.o_wb_cnt), exp_cnt(1));

        run_miss(64'h40, 1'b1, 64'hffc0, 1, 1, 1'b0);
        check("dirty_min_latency", 64'(stall_seen), 64'd4);

        // Reset in the middle of a refill drops the request.
        cycle(1'b1, 1'b0, 1'b0, 64'h7788, 64'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 64'h7788, 64'h0, 1'b0, 1'b0);
        check("pre_rst_rd_req", 64'(bus.o_axi_rd_req), 64'h1);
        do_reset(1'b0);

        // Five misses saturate a 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            run_miss(64'($urandom) << 6, 1'(i % 2), 64'h8000, 1, 2, 1'b0);
        end
        check("sat_miss_cnt", 64'(bus.o_miss_cnt), exp_cnt(5));
        check("sat_wb_cnt",   64'(bus.o_wb_cnt), exp_cnt(2));

        // Random traffic with occasional asynchronous resets.
        do_reset(1'b0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end
            cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dcache_miss_ctrl.md
DCACHE_MISS_CTRL -- requirements
Module: dcache_miss_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, width of the selected refill/writeback address.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of each performance counter.
REQ-003 SHALL have i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have i_arst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have i_mem_access  input  1  the memory-stage instruction is a load or store.
REQ-006 SHALL have i_dcache_hit  input  1  dcache tag hit for the current address.
REQ-007 SHALL have i_dcache_dirty  input  1  the victim line is dirty.
REQ-008 SHALL have i_addr  input  ADDR_WIDTH  memory-stage access address (ALU result).
REQ-009 SHALL have i_addr_wb  input  ADDR_WIDTH  victim writeback address from dcache.
REQ-010 SHALL have i_axi_wr_done  input  1  one-cycle pulse: block write to memory complete.
REQ-011 SHALL have i_axi_rd_done  input  1  one-cycle pulse: block read from memory complete, data valid.
REQ-012 SHALL have o_stall  output  1  freeze the pipeline, writeback stage included.
REQ-013 SHALL have o_axi_wr_req  output  1  level request to write the victim block.
REQ-014 SHALL have o_axi_rd_req  output  1  level request to read the missing block.
REQ-015 SHALL have o_axi_addr  output  ADDR_WIDTH  address for the active AXI request.
REQ-016 SHALL have o_block_we  output  1  one-cycle dcache block write strobe.
REQ-017 SHALL have o_miss_cnt  output  CNT_WIDTH  count of misses taken.
REQ-018 SHALL have o_wb_cnt  output  CNT_WIDTH  count of dirty writebacks.

Function
REQ-019 SHALL implement the states IDLE, WRITEBACK, REFILL and ALLOCATE.
REQ-020 SHALL define a miss as i_mem_access=1 and i_dcache_hit=0, sampled in IDLE.
REQ-021 IDLE: on a miss, SHALL go to WRITEBACK if i_dcache_dirty=1, else to REFILL; otherwise stay in IDLE.
REQ-022 WRITEBACK: SHALL hold o_axi_wr_req=1 and drive o_axi_addr=i_addr_wb; on i_axi_wr_done=1, SHALL go to REFILL.
REQ-023 REFILL: SHALL hold o_axi_rd_req=1 and drive o_axi_addr=i_addr with bits [5:0] cleared (64-byte line); on i_axi_rd_done=1, SHALL go to ALLOCATE.
REQ-024 ALLOCATE: SHALL assert o_block_we=1 for exactly this one cycle, then go to IDLE unconditionally.
REQ-025 o_stall SHALL equal (state!=IDLE) OR (state==IDLE AND miss), combinationally.
REQ-026 The stall therefore SHALL be asserted in the same cycle the miss is presented.
REQ-027 After ALLOCATE, the re-looked-up access SHALL hit and the pipeline SHALL resume.
REQ-028 In IDLE and ALLOCATE, o_axi_addr SHALL be 0.
REQ-029 o_axi_wr_req and o_axi_rd_req SHALL never both be 1.
REQ-030 A done pulse arriving in a state that does not await it SHALL be ignored.
REQ-031 A done pulse in the first cycle of its state SHALL be accepted.
REQ-032 Minimum miss latency (clean miss, done at first REFILL cycle) SHALL be 3 cycles of stall.
REQ-033 Minimum dirty-miss latency SHALL be 4 cycles of stall.
REQ-034 i_dcache_hit and i_dcache_dirty SHALL be ignored outside IDLE.

Reset
REQ-035 i_arst_n=0 SHALL immediately force IDLE and clear the counters, regardless of clock.
REQ-036 During reset, o_axi_wr_req, o_axi_rd_req, o_block_we and o_axi_addr SHALL be 0; o_stall SHALL be 0 unless a miss is presented.
REQ-037 Reset asserted mid-WRITEBACK or mid-REFILL SHALL drop the request with no completion required.
REQ-038 After reset deasserts, the first rising edge SHALL evaluate from IDLE.

Configuration
REQ-039 The macro DCACHE_PERF_CNT_EN SHALL compile the performance counters in.
REQ-040 With DCACHE_PERF_CNT_EN defined, o_miss_cnt SHALL increment on each IDLE-to-WRITEBACK or IDLE-to-REFILL transition.
REQ-041 With DCACHE_PERF_CNT_EN defined, o_wb_cnt SHALL increment on each IDLE-to-WRITEBACK transition; both counters SHALL saturate at all ones.
REQ-042 Without DCACHE_PERF_CNT_EN, both ports SHALL remain and be tied to 0, with no counter flops.

Verification
REQ-043 Clean miss, addr=0x1048, i_axi_rd_done 5 cycles later -> o_axi_rd_req with o_axi_addr=0x1040; one o_block_we; o_stall deasserts the cycle after ALLOCATE; o_miss_cnt=1.
REQ-044 Dirty miss, i_addr_wb=0x2000, wr_done after 3 cycles -> o_axi_wr_req with addr 0x2000, then o_axi_rd_req; o_wb_cnt=1, o_miss_cnt=1.
REQ-045 i_axi_rd_done pulsed during WRITEBACK -> ignored; state stays WRITEBACK until wr_done.
REQ-046 i_arst_n low mid-REFILL -> o_axi_rd_req=0 asynchronously, state IDLE, counters 0.
REQ-047 Hit, or i_mem_access=0 -> o_stall=0 and no requests; counters unchanged.
REQ-048 With the macro defined and CNT_WIDTH=2, 5 misses -> o_miss_cnt=3 (saturated); without the macro -> 0.
